// File: rtl/fsb_node_trace_replay.sv
// rtl/fsb_node_trace_replay.sv - ROM-driven trace replay engine: stimulus out, checked response in
module fsb_node_trace_replay #(
    parameter int ring_width_p     = 80,
    parameter int rom_addr_width_p = 10,
    parameter int counter_width_p  = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        yumi_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [ring_width_p+3:0]     rom_data_i,
    output logic                        done_o,
    output logic                        error_o
);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_SEND      = 4'd1;
    localparam logic [3:0] OP_RECV      = 4'd2;
    localparam logic [3:0] OP_DONE      = 4'd3;
    localparam logic [3:0] OP_WAIT_INIT = 4'd4;
    localparam logic [3:0] OP_WAIT_DEC  = 4'd5;

    logic [rom_addr_width_p-1:0] addr_r, addr_n, addr_inc;
    logic [counter_width_p-1:0]  cnt_r, cnt_n;
    logic                        done_r, done_n;
    logic                        err_r, err_n;
    logic [3:0]                  op;
    logic [ring_width_p-1:0]     payload;
    logic                        active;

    assign op         = rom_data_i[ring_width_p +: 4];
    assign payload    = rom_data_i[ring_width_p-1:0];
    assign active     = en_i & ~done_r;
    assign addr_inc   = addr_r + rom_addr_width_p'(1);
    assign rom_addr_o = addr_r;
    assign data_o     = payload;
    assign done_o     = done_r;
    assign error_o    = err_r;

    // Decode the current trace word: drive handshakes and compute next engine state
    always_comb begin
        v_o     = 1'b0;
        ready_o = 1'b0;
        addr_n  = addr_r;
        cnt_n   = cnt_r;
        done_n  = done_r;
        err_n   = err_r;
        if (active) begin
            case (op)
                OP_NOP: begin
                    addr_n = addr_inc;
                end
                OP_SEND: begin
                    v_o = 1'b1;
                    if (yumi_i) begin
                        addr_n = addr_inc;
                    end
                end
                OP_RECV: begin
                    ready_o = 1'b1;
                    if (v_i) begin
                        if (data_i != payload) begin
                            err_n = 1'b1;
                        end
                        addr_n = addr_inc;
                    end
                end
                OP_DONE: begin
                    done_n = 1'b1;
                end
                OP_WAIT_INIT: begin
                    cnt_n  = payload[counter_width_p-1:0];
                    addr_n = addr_inc;
                end
                OP_WAIT_DEC: begin
                    // Counter reaching zero releases the stall, so it lasts cnt+1 cycles
                    if (cnt_r == '0) begin
                        addr_n = addr_inc;
                    end else begin
                        cnt_n = cnt_r - counter_width_p'(1);
                    end
                end
                default: begin
                    // Illegal opcode is flagged but replay keeps going
                    err_n  = 1'b1;
                    addr_n = addr_inc;
                end
            endcase
        end
    end

    // Engine state registers; reset restarts replay from address 0
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_r <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            addr_r <= addr_n;
            cnt_r  <= cnt_n;
            done_r <= done_n;
            err_r  <= err_n;
        end
    end

endmodule

// File: tb/tb_fsb_node_trace_replay.sv
// tb/tb_fsb_node_trace_replay.sv - scoreboard bench for fsb_node_trace_replay
module tb_fsb_node_trace_replay;

    localparam int RW = 80;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          v_in = 1'b0;
    logic [RW-1:0] data_in = '0;
    logic          ready;
    logic          v_out;
    logic [RW-1:0] data_out;
    logic          yumi = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [RW+3:0] rom_data;
    logic          done;
    logic          error;

    logic [RW+3:0] rom [0:(1<<AW)-1];
    assign rom_data = rom[rom_addr];

    // Small-address instance used only for the wrap check
    logic          en2 = 1'b0;
    logic          ready2, v2, done2, err2;
    logic [RW-1:0] data2;
    logic [1:0]    rom_addr2;
    logic [RW+3:0] rom_data2;
    assign rom_data2 = '0;

    fsb_node_trace_replay #(.ring_width_p(RW), .rom_addr_width_p(AW), .counter_width_p(32)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .v_i(v_in), .data_i(data_in),
        .ready_o(ready), .v_o(v_out), .data_o(data_out), .yumi_i(yumi),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .done_o(done), .error_o(error)
    );

    fsb_node_trace_replay #(.ring_width_p(RW), .rom_addr_width_p(2), .counter_width_p(32)) dut2 (
        .clk_i(clk), .reset_i(reset), .en_i(en2), .v_i(1'b0), .data_i('0),
        .ready_o(ready2), .v_o(v2), .data_o(data2), .yumi_i(1'b0),
        .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .done_o(done2), .error_o(err2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] send_q[$];
    logic [RW-1:0] recv_q[$];
    bit rand_mode = 1'b0;
    bit prev_err = 1'b0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [RW-1:0] p;
        p[31:0]  = $urandom;
        p[63:32] = $urandom;
        p[79:64] = 16'($urandom);
        return p;
    endfunction

    // Monitor: pop expected words on every accepted send, retire receives, watch stickiness
    always @(negedge clk) begin
        if (reset) begin
            if (v_out && yumi) begin
                if (send_q.size() == 0) chk("send_unexpected", 128'(data_out), 128'(0) - 128'(1));
                else chk("send_data", 128'(data_out), 128'(send_q.pop_front()));
            end
            if (ready && v_in && recv_q.size() > 0) void'(recv_q.pop_front());
            if (prev_err) chk("error_sticky", 128'(error), 128'(1));
            prev_err = error;
        end else begin
            prev_err = 1'b0;
        end
    end

    // Driver: present the next receive word; randomize handshakes in random mode
    always @(posedge clk) begin
        #1;
        data_in = (recv_q.size() > 0) ? recv_q[0] : {RW{1'b1}};
        if (rand_mode) begin
            en   = ($urandom % 8) != 0;
            yumi = 1'($urandom % 2);
            v_in = 1'($urandom % 2);
        end
    end

    task automatic clear();
        reset = 1'b0;
        rand_mode = 1'b0;
        en = 1'b0; yumi = 1'b0; v_in = 1'b0; en2 = 1'b0;
        send_q.delete();
        recv_q.delete();
        for (int i = 0; i < (1 << AW); i++) rom[i] = {4'd3, {RW{1'b0}}};
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_done(string name, int budget);
        for (int c = 0; c < budget && !done; c++) @(negedge clk);
        @(negedge clk);
        chk(name, 128'(done), 128'(1));
    endtask

    initial begin
        logic [RW-1:0] p;
        int n;
        bit exp_err;

        // Reset state
        clear();
        chk("reset_addr", 128'(rom_addr), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_error", 128'(error), 128'(0));

        // Back-to-back sends, done on cycle 3
        clear();
        rom[0] = {4'd1, 80'hA5}; rom[1] = {4'd1, 80'h3C}; rom[2] = {4'd3, 80'h0};
        send_q.push_back(80'hA5); send_q.push_back(80'h3C);
        en = 1'b1; yumi = 1'b1;
        release_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_v", 128'(v_out), 128'(k < 2));
            chk("t1_done", 128'(done), 128'(k == 3));
        end
        chk("t1_all_sent", 128'(send_q.size()), 128'(0));

        // Receive match then mismatch
        for (int t = 0; t < 2; t++) begin
            clear();
            rom[0] = {4'd2, 80'h55}; rom[1] = {4'd3, 80'h0};
            recv_q.push_back(t == 0 ? 80'h55 : 80'h54);
            en = 1'b1; v_in = 1'b1;
            release_reset();
            wait_done("t2_done", 20);
            chk("t2_error", 128'(error), 128'(t == 1));
        end

        // Wait stall: v_o first rises 5 cycles after reset release
        clear();
        rom[0] = {4'd4, 80'd3}; rom[1] = {4'd5, 80'd0}; rom[2] = {4'd1, 80'h7}; rom[3] = {4'd3, 80'h0};
        send_q.push_back(80'h7);
        en = 1'b1; yumi = 1'b1;
        release_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_v_timing", 128'(v_out), 128'(k == 5));
        end
        wait_done("t3_done", 20);

        // Send held while yumi low
        clear();
        rom[0] = {4'd1, 80'h11}; rom[1] = {4'd3, 80'h0};
        send_q.push_back(80'h11);
        en = 1'b1;
        release_reset();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin @(posedge clk); #1; yumi = 1'b1; end
            @(negedge clk);
            chk("t4_v_hold", 128'(v_out), 128'(1));
            chk("t4_data_hold", 128'(data_out), 128'(80'h11));
            chk("t4_addr_hold", 128'(rom_addr), 128'(0));
        end
        @(negedge clk);
        chk("t4_addr_adv", 128'(rom_addr), 128'(1));
        chk("t4_all_sent", 128'(send_q.size()), 128'(0));

        // Enable drop at addr 2, illegal opcode, async reset mid-trace
        clear();
        for (int i = 0; i < 16; i++) rom[i] = {4'd0, 80'h0};
        rom[2] = {4'd1, 80'h11}; rom[3] = {4'd9, 80'h0};
        send_q.push_back(80'h11);
        en = 1'b1; yumi = 1'b1;
        release_reset();
        @(posedge clk); @(posedge clk); #1; en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_v_gated", 128'(v_out), 128'(0));
            chk("t5_ready_gated", 128'(ready), 128'(0));
            chk("t5_addr_hold", 128'(rom_addr), 128'(2));
        end
        @(posedge clk); #1; en = 1'b1;
        @(negedge clk);
        chk("t5_resend_v", 128'(v_out), 128'(1));
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("t6_illegal_err", 128'(error), 128'(1));
        chk("t6_illegal_adv", 128'(rom_addr), 128'(4));
        chk("t5_all_sent", 128'(send_q.size()), 128'(0));
        reset = 1'b0;
        #1;
        chk("t5_async_addr", 128'(rom_addr), 128'(0));
        chk("t5_async_err", 128'(error), 128'(0));
        chk("t5_async_done", 128'(done), 128'(0));

        // Address wrap on the 2-bit instance
        clear();
        en2 = 1'b1;
        release_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6_wrap_addr", 128'(rom_addr2), 128'(k % 4));
        end

        // Randomized traces against a queue-based model
        for (int run = 0; run < 6; run++) begin
            clear();
            n = 0;
            exp_err = 1'b0;
            for (int i = 0; i < 40; i++) begin
                p = rand_word();
                case ($urandom % 10)
                    0, 9: rom[n] = {4'd0, p};
                    1, 2, 3: begin rom[n] = {4'd1, p}; send_q.push_back(p); end
                    4, 5, 6: begin
                        rom[n] = {4'd2, p};
                        if ($urandom % 4 == 0) begin
                            recv_q.push_back(p ^ (80'd1 << ($urandom % RW)));
                            exp_err = 1'b1;
                        end else begin
                            recv_q.push_back(p);
                        end
                    end
                    7: begin
                        rom[n] = {4'd4, 76'd0, 4'($urandom % 5)};
                        n++;
                        rom[n] = {4'd5, p};
                    end
                    default: begin
                        rom[n] = {4'(6 + $urandom % 10), p};
                        exp_err = 1'b1;
                    end
                endcase
                n++;
            end
            rom[n] = {4'd3, rand_word()};
            rand_mode = 1'b1;
            release_reset();
            wait_done("rnd_done", 3000);
            rand_mode = 1'b0;
            @(negedge clk);
            chk("rnd_error", 128'(error), 128'(exp_err));
            chk("rnd_addr_at_done", 128'(rom_addr), 128'(n));
            chk("rnd_sends_left", 128'(send_q.size()), 128'(0));
            chk("rnd_recvs_left", 128'(recv_q.size()), 128'(0));
            chk("rnd_v_after_done", 128'(v_out | ready), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
